// File: rtl/ex_div_pkg.sv
// Shared definitions for the EX-stage divider.
// State encodings and handshake levels.
package ex_div_pkg;

    localparam logic RstEnable = 1'b1;
    localparam logic LogiTrue  = 1'b1;

    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;

    localparam logic DivStart = 1'b1;
    localparam logic DivStop  = 1'b0;

    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_e;

endpackage

// File: rtl/ex_div.sv
// Radix-2 restoring divider for DIV/DIVU in EX.
// Holds the pipeline via stallreq_o until {HI, LO} is ready.
module ex_div
    import ex_div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               start_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o,
    output logic               stallreq_o
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LastIter = CW'(WIDTH - 1);

    div_state_e       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] dabs;
    logic             neg_q;
    logic             neg_r;

    logic [WIDTH:0]   t;
    logic [WIDTH-1:0] r_nx;
    logic [WIDTH-1:0] q_nx;
    logic [WIDTH-1:0] r_fix;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] d_abs;
    logic             go;

    // One restoring step plus operand magnitudes and sign fix-up.
    always_comb begin
        t     = {r, q[WIDTH-1]} - {1'b0, dabs};
        r_nx  = t[WIDTH] ? {r[WIDTH-2:0], q[WIDTH-1]} : t[WIDTH-1:0];
        q_nx  = {q[WIDTH-2:0], ~t[WIDTH]};
        q_fix = neg_q ? -q_nx : q_nx;
        r_fix = neg_r ? -r_nx : r_nx;
        a_abs = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
        d_abs = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
        go    = (start_i == DivStart) && (annul_i != LogiTrue);
    end

    // Stall while a divide sits in EX without a result, unless it is flushed.
    assign stallreq_o = (start_i == DivStart) && (ready_o == DivResultNotReady)
                        && (annul_i != LogiTrue);

    // Divider FSM and datapath; outputs are registered.
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state    <= DivFree;
            cnt      <= '0;
            r        <= '0;
            q        <= '0;
            dabs     <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            result_o <= '0;
            ready_o  <= DivResultNotReady;
        end else begin
            unique case (state)
                DivFree: begin
                    if (go && opdata2_i == '0) begin
                        state <= DivByZero;
                    end else if (go) begin
                        state <= DivOn;
                        cnt   <= '0;
                        r     <= '0;
                        q     <= a_abs;
                        dabs  <= d_abs;
                        neg_q <= signed_div_i && (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
                        neg_r <= signed_div_i && opdata1_i[WIDTH-1];
                    end
                end
                DivByZero: begin
                    if (annul_i == LogiTrue) begin
                        state <= DivFree;
                    end else begin
                        state    <= DivEnd;
                        result_o <= '0;
                        ready_o  <= DivResultReady;
                    end
                end
                DivOn: begin
                    if (annul_i == LogiTrue) begin
                        state <= DivFree;
                        cnt   <= '0;
                    end else begin
                        r   <= r_nx;
                        q   <= q_nx;
                        cnt <= cnt + 1'b1;
                        if (cnt == LastIter) begin
                            state    <= DivEnd;
                            result_o <= {r_fix, q_fix};
                            ready_o  <= DivResultReady;
                        end
                    end
                end
                DivEnd: begin
                    if (start_i == DivStop) begin
                        state    <= DivFree;
                        result_o <= '0;
                        ready_o  <= DivResultNotReady;
                    end
                end
                default: state <= DivFree;
            endcase
        end
    end

endmodule

// File: doc/ex_div.md
# ex_div

Multi-cycle radix-2 restoring divider for the EX stage, executing DIV/DIVU. It is the requesting end of the pipeline stall handshake. While a division is in flight it drives `stallreq_o`, which feeds `stallreq_from_ex` of the pipeline controller. The controller then freezes PC, IF/ID, ID/EX and EX/MEM, so the divide instruction stays in EX and keeps `start_i` asserted until the quotient and remainder are ready for HI/LO.

## Interface
Parameters:
- `WIDTH`, 32: operand width. Result width is 2*WIDTH. Iteration count is WIDTH.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `signed_div_i` in 1: 1 = DIV (two's complement), 0 = DIVU.
- `opdata1_i` in WIDTH: dividend.
- `opdata2_i` in WIDTH: divisor.
- `start_i` in 1: high while the EX instruction is a divide. Held by the stalled pipeline.
- `annul_i` in 1: abort the current division (exception or flush).
- `result_o` out 2*WIDTH: {remainder, quotient}, i.e. {HI, LO}.
- `ready_o` out 1: result valid.
- `stallreq_o` out 1: stall request to the pipeline controller.

## Operation
- The FSM has four states: FREE, BY_ZERO, ON, END.
- **FREE:**
  - If `start_i` && !`annul_i` and divisor == 0: go to BY_ZERO.
  - If `start_i` && !`annul_i` and divisor != 0: go to ON. Latch absolute values when signed, raw values otherwise. Clear the iteration counter, set R = 0 and Q = |dividend|.
  - Otherwise stay in FREE.
- **BY_ZERO:** load result = 0, then go to END.
- **ON:** one iteration per cycle.
  - Compute T = {R[W-1:0], Q[W-1]} − {1'b0, |D|} (W+1 bits).
  - If T[W] == 1: R ← {R[W-1:0], Q[W-1]}, Q ← {Q[W-2:0], 0}.
  - Else: R ← T[W-1:0], Q ← {Q[W-2:0], 1}.
  - Counter increments each cycle. After iteration WIDTH (counter == WIDTH−1 on entry), apply sign fix-up and go to END.
  - `annul_i` high in ON: go to FREE; the result is discarded.
- **Sign fix-up (signed only):**
  - Quotient is negated when the operand signs differ.
  - Remainder takes the dividend's sign.
  - Arithmetic wraps modulo 2^W. 0x80000000 / −1 gives Q = 0x80000000, R = 0, with no trap.
- **END:** `ready_o` = 1 and `result_o` holds. Stay in END while `start_i` = 1. When `start_i` drops, go to FREE, clear `ready_o` and clear `result_o`.
- **`stallreq_o`** (combinational) = `start_i` && !`ready_o` && !`annul_i`. It is low in FREE when `start_i` = 0, and low in END.
- **Reset:** `rst` at any point, including mid-ON, forces FREE, `result_o` = 0, `ready_o` = 0, counter = 0 on the next edge. `rst` has priority over `annul_i`, which has priority over `start_i`.
- **Back-to-back divides:** the next divide is accepted only from FREE. A `start_i` low cycle between instructions (the pipeline advancing) is always present.

## Timing
- Cycle 0: `start_i` rises in FREE and `stallreq_o` = 1 in the same cycle.
- Non-zero divisor:
  - ON occupies cycles 1..WIDTH.
  - END is entered at cycle WIDTH+1 (33 for W = 32). `ready_o` = 1 and `stallreq_o` = 0 in that cycle.
  - Total stall: WIDTH+1 cycles.
- Divide by zero: BY_ZERO in cycle 1, END (`ready_o`) in cycle 2, giving a 2-cycle stall.
- Annul in cycle k of ON: `stallreq_o` drops in cycle k (combinational), FREE at k+1, `ready_o` never asserted.
- Operands are sampled only on the FREE→ON/BY_ZERO transition. Later operand changes are ignored.

## Structure
- Shared defines header gets:
  - State encodings DivFree, DivByZero, DivOn, DivEnd (2 bits).
  - DivResultReady/NotReady.
  - DivStart/DivStop.
- Existing LogiTrue/RstEnable are reused.
- A single module holds the FSM plus the datapath (R, Q, counter, sign flags). No sub-module is needed.
- The stall vector is not decoded here; the pipeline controller owns it. With `stallreq_from_ex` high it outputs 6'b001111.

## Test plan
- **Unsigned 100 / 7:** `start_i` held at cycle 0. Requires `stallreq_o` high for cycles 0–32, `ready_o` at cycle 33, `result_o` = 0x00000002_0000000E.
- **Signed −100 / 7** (0xFFFFFF9C, 0x00000007): requires `result_o` = 0xFFFFFFFE_FFFFFFF2 at cycle 33. Also check signed 0x80000000 / 0xFFFFFFFF gives 0x00000000_80000000.
- **5 / 0** (signed and unsigned): requires `ready_o` at cycle 2, `result_o` = 0, `stallreq_o` high for cycles 0–1 only.
- **DIVU 0xFFFFFFFF / 1:** requires 0x00000000_FFFFFFFF. Drop `start_i` at cycle 34: FREE at 35 with `ready_o` = 0, `result_o` = 0. A new divide at 36 is accepted.
- **Annul at cycle 10:** `stallreq_o` = 0 in cycle 10, FREE at 11, `ready_o` never 1. A following 9 / 3 gives 0x00000000_00000003.
- **`rst` at cycle 15 of ON:** requires all outputs 0 and state FREE at 16. `rst` asserted together with `start_i` must not start a division.
